// File: rtl/dsp_fft_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT frames in, natural bin order out on a valid/ready
// stream. Define FFT_REORDER_IDX_EN to add the dout_idx output (natural bin index of dout).
module dsp_fft_bitrev_reorder #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned PTN    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*DATA_W-1:0]     din,
  input  logic                    din_vld,
  output logic                    din_busy,
  output logic [2*DATA_W-1:0]     dout,
  output logic                    dout_vld,
  input  logic                    dout_rdy,
  output logic                    dout_last,
`ifdef FFT_REORDER_IDX_EN
  output logic [$clog2(PTN)-1:0]  dout_idx,
`endif
  output logic                    ovf
);

  localparam int unsigned CTW = $clog2(PTN);
  localparam int unsigned SW  = 2 * DATA_W;
  localparam logic [CTW-1:0] LastIdx = CTW'(PTN - 1);

  typedef enum logic [1:0] {BkEmpty, BkFilling, BkFull, BkDraining} bank_st_e;

  function automatic logic [CTW-1:0] bitrev(input logic [CTW-1:0] a);
    logic [CTW-1:0] r;
    for (int i = 0; i < int'(CTW); i++) r[i] = a[CTW-1-i];
    return r;
  endfunction

  bank_st_e       bank_st_q [2];
  bank_st_e       bank_st_d [2];
  logic           wr_ptr_q, rd_ptr_q;
  logic [CTW-1:0] wr_cnt_q, rd_cnt_q;
  logic           ovf_q;
  logic [SW-1:0]  mem_q [2*PTN];

  bank_st_e       wr_st, rd_st;
  logic           wr_ok, wr_en, fill_done;
  logic           rd_en, drain_done;

  // Read pipeline stage (memory output) and 2-entry skid ahead of the output register
  logic           rd_vld_q, rd_last_q;
  logic [SW-1:0]  rd_data_q;
  logic [SW-1:0]  fifo_data_q [2];
  logic [1:0]     fifo_last_q;
  logic           fifo_wsel_q, fifo_rsel_q;
  logic [1:0]     fifo_cnt_q;

  logic [SW-1:0]  dout_q;
  logic           dout_vld_q, dout_last_q;

  logic           push, pop, out_load;
  logic [2:0]     occ;

`ifdef FFT_REORDER_IDX_EN
  logic [CTW-1:0] rd_idx_q;
  logic [CTW-1:0] fifo_idx_q [2];
  logic [CTW-1:0] dout_idx_q;
`endif

  assign wr_st = bank_st_q[wr_ptr_q];
  assign rd_st = bank_st_q[rd_ptr_q];

  assign wr_ok     = (wr_st == BkEmpty) || (wr_st == BkFilling);
  assign wr_en     = din_vld && wr_ok;
  assign fill_done = wr_en && (wr_cnt_q == LastIdx);
  assign din_busy  = !wr_ok;

  // Samples held or in flight downstream; output reg + skid give room for three.
  assign pop        = dout_vld_q && dout_rdy;
  assign occ        = 3'(dout_vld_q) + 3'(fifo_cnt_q) + 3'(rd_vld_q);
  assign rd_en      = ((rd_st == BkFull) || (rd_st == BkDraining)) && ((occ - 3'(pop)) < 3'd3);
  assign drain_done = rd_en && (rd_cnt_q == LastIdx);

  assign push     = rd_vld_q;
  assign out_load = (fifo_cnt_q != 2'd0) && (!dout_vld_q || dout_rdy);

  always_comb begin
    for (int b = 0; b < 2; b++) bank_st_d[b] = bank_st_q[b];
    if (rd_st == BkFull) bank_st_d[rd_ptr_q] = BkDraining;
    if (drain_done)      bank_st_d[rd_ptr_q] = BkEmpty;
    if (wr_en)           bank_st_d[wr_ptr_q] = fill_done ? BkFull : BkFilling;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_st_q[0] <= BkEmpty;
      bank_st_q[1] <= BkEmpty;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      ovf_q        <= 1'b0;
    end else begin
      bank_st_q[0] <= bank_st_d[0];
      bank_st_q[1] <= bank_st_d[1];
      if (wr_en) begin
        wr_cnt_q <= wr_cnt_q + 1'b1;
        if (fill_done) wr_ptr_q <= ~wr_ptr_q;
      end
      if (din_vld && !wr_ok) ovf_q <= 1'b1;
      if (rd_en) begin
        rd_cnt_q <= rd_cnt_q + 1'b1;
        if (drain_done) rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // Storage without reset; validity is tracked by the control flops.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[{wr_ptr_q, bitrev(wr_cnt_q)}] <= din;
    if (rd_en) rd_data_q <= mem_q[{rd_ptr_q, rd_cnt_q}];
    if (push) begin
      fifo_data_q[fifo_wsel_q] <= rd_data_q;
      fifo_last_q[fifo_wsel_q] <= rd_last_q;
`ifdef FFT_REORDER_IDX_EN
      fifo_idx_q[fifo_wsel_q]  <= rd_idx_q;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      fifo_wsel_q <= 1'b0;
      fifo_rsel_q <= 1'b0;
      fifo_cnt_q  <= 2'd0;
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
      dout_last_q <= 1'b0;
`ifdef FFT_REORDER_IDX_EN
      rd_idx_q    <= '0;
      dout_idx_q  <= '0;
`endif
    end else begin
      rd_vld_q  <= rd_en;
      rd_last_q <= drain_done;
`ifdef FFT_REORDER_IDX_EN
      if (rd_en) rd_idx_q <= rd_cnt_q;
`endif
      if (push)     fifo_wsel_q <= ~fifo_wsel_q;
      if (out_load) fifo_rsel_q <= ~fifo_rsel_q;
      fifo_cnt_q <= fifo_cnt_q + 2'(push) - 2'(out_load);
      if (out_load) begin
        dout_q      <= fifo_data_q[fifo_rsel_q];
        dout_last_q <= fifo_last_q[fifo_rsel_q];
        dout_vld_q  <= 1'b1;
`ifdef FFT_REORDER_IDX_EN
        dout_idx_q  <= fifo_idx_q[fifo_rsel_q];
`endif
      end else if (pop) begin
        dout_vld_q  <= 1'b0;
        dout_last_q <= 1'b0;
      end
    end
  end

  assign dout      = dout_q;
  assign dout_vld  = dout_vld_q;
  assign dout_last = dout_last_q;
  assign ovf       = ovf_q;
`ifdef FFT_REORDER_IDX_EN
  assign dout_idx  = dout_idx_q;
`endif

`ifndef SYNTHESIS
  // Fill and drain always target opposite banks; a collision means the control is broken.
  bank_collision_a : assert property (@(posedge clk) disable iff (rst)
    !(fill_done && drain_done && (wr_ptr_q == rd_ptr_q)));
  skid_overflow_a : assert property (@(posedge clk) disable iff (rst)
    !(push && !out_load && (fifo_cnt_q == 2'd2)));
`endif

endmodule

// File: tb/tb_dsp_fft_bitrev_reorder.sv
// Scoreboard bench for dsp_fft_bitrev_reorder (PTN=8): directed frames, monitor pops and compares.
module tb_dsp_fft_bitrev_reorder;

  localparam int DW = 16;

  typedef struct {
    logic [2*DW-1:0] data;
    logic            last;
    int              idx;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [2*DW-1:0] din;
  logic            din_vld;
  logic            din_busy;
  logic [2*DW-1:0] dout;
  logic            dout_vld;
  logic            dout_rdy;
  logic            dout_last;
  logic            ovf;
`ifdef FFT_REORDER_IDX_EN
  logic [2:0]      dout_idx;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  exp_t exp_q[$];
  int xfer_n, xfer_first, xfer_last;
  logic busy_seen;
  logic prev_stall;
  logic [2*DW-1:0] prev_dout;
  logic prev_last;

  dsp_fft_bitrev_reorder #(.DATA_W(DW), .PTN(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_vld   (din_vld),
    .din_busy  (din_busy),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .dout_rdy  (dout_rdy),
    .dout_last (dout_last),
`ifdef FFT_REORDER_IDX_EN
    .dout_idx  (dout_idx),
`endif
    .ovf       (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, want);
    end
  endtask

  // Expected natural-order output of a frame whose inputs were base+0 .. base+7.
  task automatic push_frame(input logic [2*DW-1:0] base);
    int tbl[8];
    exp_t e;
    tbl = '{0, 4, 2, 6, 1, 5, 3, 7};
    for (int k = 0; k < 8; k++) begin
      e.data = base + tbl[k];
      e.last = (k == 7);
      e.idx  = k;
      exp_q.push_back(e);
    end
  endtask

  // Called between edges; returns #1 after the capturing edge.
  task automatic send(input logic [2*DW-1:0] v);
    din     = v;
    din_vld = 1'b1;
    @(posedge clk);
    #1;
    din_vld = 1'b0;
  endtask

  task automatic wait_drain(input int mode, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || dout_vld) && n < budget) begin
      @(posedge clk);
      #1;
      dout_rdy = (mode == 0) ? 1'b1 : ((n % 3) == 0);
      n++;
    end
    dout_rdy = 1'b1;
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL drain_timeout got=%0d pending expected=0", exp_q.size());
    end
  endtask

  always @(negedge clk) begin
    if (!rst && din_busy) busy_seen = 1'b1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!dout_vld || dout !== prev_dout || dout_last !== prev_last) begin
          failures++;
          $display("FAIL hold got=%0h/%0b/%0b expected=%0h/1/%0b",
                   dout, dout_vld, dout_last, prev_dout, prev_last);
        end
      end
      if (dout_vld && dout_rdy) begin
        checks++;
        if (xfer_n == 0) xfer_first = cyc;
        xfer_last = cyc;
        xfer_n++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output got=%0h expected=none", dout);
        end else begin
          e = exp_q.pop_front();
          if (dout !== e.data || dout_last !== e.last) begin
            failures++;
            $display("FAIL dout got=%0h last=%0b expected=%0h last=%0b",
                     dout, dout_last, e.data, e.last);
          end
`ifdef FFT_REORDER_IDX_EN
          else if (int'(dout_idx) != e.idx) begin
            failures++;
            $display("FAIL dout_idx got=%0d expected=%0d", dout_idx, e.idx);
          end
`endif
        end
      end
      prev_stall = dout_vld && !dout_rdy;
      prev_dout  = dout;
      prev_last  = dout_last;
    end
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog got=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int lat;
    rst = 1'b1; din = '0; din_vld = 1'b0; dout_rdy = 1'b1;
    xfer_n = 0; xfer_first = 0; xfer_last = 0; busy_seen = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_dout_vld", 64'(dout_vld), 64'd0);
    check("rst_dout_last", 64'(dout_last), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_din_busy", 64'(din_busy), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single frame, latency and contiguity
    xfer_n = 0;
    push_frame(32'd0);
    for (int i = 0; i < 8; i++) send(32'(i));
    lat = 0;
    while (!dout_vld && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("s1_latency", 64'(lat), 64'd3);
    wait_drain(0, 60);
    check("s1_count", 64'(xfer_n), 64'd8);
    check("s1_span", 64'(xfer_last - xfer_first + 1), 64'd8);

    // Two back-to-back frames
    xfer_n = 0; busy_seen = 1'b0;
    push_frame(32'd0);
    push_frame(32'd8);
    for (int i = 0; i < 16; i++) send(32'(i));
    wait_drain(0, 80);
    check("s2_count", 64'(xfer_n), 64'd16);
    check("s2_span", 64'(xfer_last - xfer_first + 1), 64'd16);
    check("s2_busy_seen", 64'(busy_seen), 64'd0);
    check("s2_ovf", 64'(ovf), 64'd0);

    // Backpressure pattern 1,0,0 during drain
    xfer_n = 0;
    push_frame(32'h50);
    for (int i = 0; i < 8; i++) send(32'h50 + 32'(i));
    wait_drain(1, 120);
    check("s3_count", 64'(xfer_n), 64'd8);

    // Three frames with consumer stalled: third frame dropped
    xfer_n = 0;
    dout_rdy = 1'b0;
    push_frame(32'h100);
    push_frame(32'h108);
    for (int i = 0; i < 24; i++) begin
      send(32'h100 + 32'(i));
      if (i == 14) begin
        @(negedge clk);
        check("s4_busy_before", 64'(din_busy), 64'd0);
      end
      if (i == 15) begin
        @(negedge clk);
        check("s4_busy_after16", 64'(din_busy), 64'd1);
        check("s4_ovf_before", 64'(ovf), 64'd0);
      end
    end
    @(negedge clk);
    check("s4_ovf_after", 64'(ovf), 64'd1);
    @(posedge clk);
    #1;
    wait_drain(0, 200);
    repeat (12) @(posedge clk);
    #1;
    check("s4_count", 64'(xfer_n), 64'd16);
    check("s4_ovf_sticky", 64'(ovf), 64'd1);

    // Reset mid-frame
    for (int i = 0; i < 5; i++) send(32'h200 + 32'(i));
    rst = 1'b1;
    @(negedge clk);
    check("s5_dout", 64'(dout), 64'd0);
    check("s5_dout_vld", 64'(dout_vld), 64'd0);
    check("s5_dout_last", 64'(dout_last), 64'd0);
    check("s5_ovf", 64'(ovf), 64'd0);
    check("s5_din_busy", 64'(din_busy), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    xfer_n = 0;
    push_frame(32'h300);
    for (int i = 0; i < 8; i++) send(32'h300 + 32'(i));
    wait_drain(0, 60);
    check("s5_count", 64'(xfer_n), 64'd8);
    check("s5_ovf_after", 64'(ovf), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
